ti_packet_rx: RTL and testbench
===============================

// Module: ti_packet_rx
// PURPOSE
//  Receive-side NoC packet deframer for the Task Injector. Consumes a credit-based flit stream
//  (target, size, body), captures the first HEADER_SIZE body flits into a parallel header buffer,
//  validates the service word, then streams the remaining payload with valid/ready.
//  Generalises the fixed 32-bit, 13-word header handling to parametrised flit width and header depth.
// PARAMETERS
//  FLIT_SIZE      32  flit/word width in bits
//  HEADER_SIZE    13  body flits captured as header (>=1)
//  CHECK_SERVICE  1   1: drop packets whose service is not a known code; 0: accept any
// PORTS
//  clk_i           in   1                        clock
//  rst_ni          in   1                        asynchronous active-low reset
//  rx_i            in   1                        flit valid from NoC
//  data_i          in   FLIT_SIZE                flit data
//  credit_o        out  1                        flit accepted when rx_i && credit_o
//  target_o        out  FLIT_SIZE                captured target flit
//  hdr_valid_o     out  1                        header buffer valid
//  hdr_ready_i     in   1                        header consumed
//  hdr_o           out  HEADER_SIZE*FLIT_SIZE    header; word k at [k*FLIT_SIZE +: FLIT_SIZE]
//  service_o       out  FLIT_SIZE                alias of header word 0
//  payload_size_o  out  FLIT_SIZE                size - HEADER_SIZE, valid with hdr_valid_o
//  pld_valid_o     out  1                        payload flit valid
//  pld_ready_i     in   1                        payload sink ready
//  pld_data_o      out  FLIT_SIZE                payload flit
//  pld_last_o      out  1                        final payload flit
//  err_o           out  1                        one-cycle error pulse
//  err_code_o      out  2                        1: size<HEADER_SIZE, 2: unknown service; held until next err
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state IDLE; all outputs 0; hdr_o/target_o/counters/err_code_o cleared.
//  - Accept = rx_i && credit_o. credit_o=1 in IDLE, SIZE, HEADER, DROP; 0 in HDR_OUT;
//    in PAYLOAD credit_o=pld_ready_i, pld_valid_o=rx_i, pld_data_o=data_i (zero-latency pass-through).
//  - IDLE: accept -> target_o<=data_i, go SIZE.
//  - SIZE: accept -> latch size into remaining counter. If size<HEADER_SIZE: err_o pulse, code 1,
//    go DROP (or IDLE if size==0). Else idx<=0, go HEADER.
//  - HEADER: accept -> hdr word[idx]<=data_i, remaining--. On word HEADER_SIZE-1: if CHECK_SERVICE
//    and word0 not in {0x00,0x01,0x10,0x26,0x31,0x34,0x40}: err_o pulse, code 2, go DROP (IDLE if
//    remaining==0). Else go HDR_OUT.
//  - HDR_OUT: hdr_valid_o=1, fields stable; on hdr_ready_i -> PAYLOAD if payload_size_o!=0 else IDLE.
//  - PAYLOAD: per accept remaining--; pld_last_o=pld_valid_o && remaining==1; last accept -> IDLE.
//  - DROP: accept and discard until remaining reaches 0, then IDLE; no pld/hdr outputs.
//  - Header never overlaps payload: hdr_valid_o and pld_valid_o never both 1.
//  - Counter arithmetic FLIT_SIZE wide, unsigned; size 0xFFFFFFFF legal (no wrap, counts down).
//  - Back-to-back packets: new target flit accepted in the cycle after returning to IDLE.
//  - Reset mid-packet discards all state; partial packet is not recovered.
// TESTING
//  - Reset: rst_ni=0 mid-PAYLOAD -> all outputs 0 immediately, credit_o=1 after release (IDLE).
//  - size=15, service 0x01, 2 payload flits -> hdr_valid_o with payload_size_o=2; after hdr_ready_i
//    2 pld beats, pld_last_o on second; back to IDLE.
//  - size=13, service 0x40 -> hdr_valid_o, payload_size_o=0, hdr_ready_i -> IDLE, no pld_valid_o.
//  - size=5 -> err_o pulse, err_code_o=1, 5 flits consumed, no hdr_valid_o.
//  - size=20, service 0x99, CHECK_SERVICE=1 -> err_code_o=2, 7 remaining flits dropped; with
//    CHECK_SERVICE=0 the header is presented normally.
//  - pld_ready_i toggling 1/0 each cycle, 4 payload flits -> credit_o follows pld_ready_i, data in order.

Source files
------------

// File: rtl/ti_packet_rx_if.sv
// Flit link, header buffer and payload stream of the Task Injector receive deframer.
// slave faces the deframer; master faces the NoC/sink side.
interface ti_packet_rx_if #(
   parameter int unsigned FLIT_SIZE   = 32,
   parameter int unsigned HEADER_SIZE = 13
);
   logic                              rx_i;
   logic [FLIT_SIZE-1:0]              data_i;
   logic                              credit_o;
   logic [FLIT_SIZE-1:0]              target_o;
   logic                              hdr_valid_o;
   logic                              hdr_ready_i;
   logic [HEADER_SIZE*FLIT_SIZE-1:0]  hdr_o;
   logic [FLIT_SIZE-1:0]              service_o;
   logic [FLIT_SIZE-1:0]              payload_size_o;
   logic                              pld_valid_o;
   logic                              pld_ready_i;
   logic [FLIT_SIZE-1:0]              pld_data_o;
   logic                              pld_last_o;
   logic                              err_o;
   logic [1:0]                        err_code_o;

   modport slave (
      input  rx_i, data_i, hdr_ready_i, pld_ready_i,
      output credit_o, target_o, hdr_valid_o, hdr_o, service_o,
      output payload_size_o, pld_valid_o, pld_data_o, pld_last_o,
      output err_o, err_code_o
   );

   modport master (
      output rx_i, data_i, hdr_ready_i, pld_ready_i,
      input  credit_o, target_o, hdr_valid_o, hdr_o, service_o,
      input  payload_size_o, pld_valid_o, pld_data_o, pld_last_o,
      input  err_o, err_code_o
   );
endinterface

// File: rtl/ti_packet_rx.sv
// Task Injector NoC deframer: target, size, header capture, service check,
// then zero-latency payload pass-through with valid/ready.
module ti_packet_rx #(
   parameter int unsigned FLIT_SIZE     = 32,
   parameter int unsigned HEADER_SIZE   = 13,
   parameter bit          CHECK_SERVICE = 1'b1
) (
   input logic          clk_i,
   input logic          rst_ni,
   ti_packet_rx_if.slave bus
);

   localparam int unsigned HW = HEADER_SIZE * FLIT_SIZE;
   localparam int unsigned IW = (HEADER_SIZE > 1) ? $clog2(HEADER_SIZE) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SIZE,
      S_HEADER,
      S_HDR_OUT,
      S_PAYLOAD,
      S_DROP
   } state_e;

   state_e               state_q, state_d;
   logic [FLIT_SIZE-1:0] target_q;
   logic [FLIT_SIZE-1:0] remaining_q;
   logic [FLIT_SIZE-1:0] psize_q;
   logic [HW-1:0]        hdr_q;
   logic [IW-1:0]        idx_q;
   logic                 err_q;
   logic [1:0]           err_code_q;

   logic                 credit_raw;
   logic                 credit;
   logic                 accept;
   logic                 err_set;
   logic [1:0]           err_code_n;
   logic                 hdr_valid;
   logic                 pld_valid;
   logic                 pld_last;
   logic [FLIT_SIZE-1:0] pld_data;

   logic [FLIT_SIZE-1:0] rem_dec;
   logic                 size_short;
   logic                 hdr_last;
   logic [FLIT_SIZE-1:0] svc;
   logic                 svc_bad;

   function automatic logic svc_known(input logic [FLIT_SIZE-1:0] s);
      case (s)
         FLIT_SIZE'(8'h00),
         FLIT_SIZE'(8'h01),
         FLIT_SIZE'(8'h10),
         FLIT_SIZE'(8'h26),
         FLIT_SIZE'(8'h31),
         FLIT_SIZE'(8'h34),
         FLIT_SIZE'(8'h40): return 1'b1;
         default:           return 1'b0;
      endcase
   endfunction

   assign rem_dec    = remaining_q - FLIT_SIZE'(1);
   assign size_short = bus.data_i < FLIT_SIZE'(HEADER_SIZE);
   assign hdr_last   = idx_q == IW'(HEADER_SIZE - 1);
   // With a one-word header the service word is still on the bus.
   assign svc        = (HEADER_SIZE == 1) ? bus.data_i
                                          : hdr_q[FLIT_SIZE-1:0];
   assign svc_bad    = CHECK_SERVICE && !svc_known(svc);

   always_comb begin
      credit_raw = 1'b0;
      unique case (state_q)
         S_IDLE,
         S_SIZE,
         S_HEADER,
         S_DROP:    credit_raw = 1'b1;
         S_PAYLOAD: credit_raw = bus.pld_ready_i;
         default:   credit_raw = 1'b0;
      endcase
   end

   // Held low while reset is asserted so no flit is acknowledged.
   assign credit = credit_raw && rst_ni;
   assign accept = bus.rx_i && credit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      err_set    = 1'b0;
      err_code_n = err_code_q;
      hdr_valid  = 1'b0;
      pld_valid  = 1'b0;
      pld_last   = 1'b0;
      pld_data   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_SIZE;
         end
         S_SIZE: begin
            if (accept) begin
               if (size_short) begin
                  err_set    = 1'b1;
                  err_code_n = 2'd1;
                  state_d    = (bus.data_i == '0) ? S_IDLE : S_DROP;
               end else begin
                  state_d = S_HEADER;
               end
            end
         end
         S_HEADER: begin
            if (accept && hdr_last) begin
               if (svc_bad) begin
                  err_set    = 1'b1;
                  err_code_n = 2'd2;
                  state_d    = (rem_dec == '0) ? S_IDLE : S_DROP;
               end else begin
                  state_d = S_HDR_OUT;
               end
            end
         end
         S_HDR_OUT: begin
            hdr_valid = 1'b1;
            if (bus.hdr_ready_i) begin
               state_d = (remaining_q != '0) ? S_PAYLOAD : S_IDLE;
            end
         end
         S_PAYLOAD: begin
            pld_valid = bus.rx_i;
            pld_data  = bus.data_i;
            pld_last  = bus.rx_i && (remaining_q == FLIT_SIZE'(1));
            if (accept && remaining_q == FLIT_SIZE'(1)) state_d = S_IDLE;
         end
         S_DROP: begin
            if (accept && remaining_q == FLIT_SIZE'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         target_q    <= '0;
         remaining_q <= '0;
         psize_q     <= '0;
         hdr_q       <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         err_q <= err_set;
         if (err_set) err_code_q <= err_code_n;
         if (accept) begin
            unique case (state_q)
               S_IDLE: target_q <= bus.data_i;
               S_SIZE: begin
                  remaining_q <= bus.data_i;
                  psize_q     <= bus.data_i - FLIT_SIZE'(HEADER_SIZE);
                  idx_q       <= '0;
               end
               S_HEADER: begin
                  hdr_q[idx_q*FLIT_SIZE +: FLIT_SIZE] <= bus.data_i;
                  idx_q       <= idx_q + IW'(1);
                  remaining_q <= rem_dec;
               end
               S_PAYLOAD,
               S_DROP:  remaining_q <= rem_dec;
               default: ;
            endcase
         end
      end
   end

   assign bus.credit_o       = credit;
   assign bus.target_o       = target_q;
   assign bus.hdr_valid_o    = hdr_valid;
   assign bus.hdr_o          = hdr_q;
   assign bus.service_o      = hdr_q[FLIT_SIZE-1:0];
   assign bus.payload_size_o = psize_q;
   assign bus.pld_valid_o    = pld_valid;
   assign bus.pld_data_o     = pld_data;
   assign bus.pld_last_o     = pld_last;
   assign bus.err_o          = err_q;
   assign bus.err_code_o     = err_code_q;

endmodule

// File: tb/tb_ti_packet_rx.sv
// Directed bench for ti_packet_rx; a second instance with the service
// check disabled shares the same stimulus.
module tb_ti_packet_rx;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   ti_packet_rx_if #(.FLIT_SIZE(32), .HEADER_SIZE(13)) a ();
   ti_packet_rx_if #(.FLIT_SIZE(32), .HEADER_SIZE(13)) b ();

   assign b.rx_i        = a.rx_i;
   assign b.data_i      = a.data_i;
   assign b.hdr_ready_i = a.hdr_ready_i;
   assign b.pld_ready_i = a.pld_ready_i;

   ti_packet_rx #(.FLIT_SIZE(32), .HEADER_SIZE(13), .CHECK_SERVICE(1'b1)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (a)
   );

   ti_packet_rx #(.FLIT_SIZE(32), .HEADER_SIZE(13), .CHECK_SERVICE(1'b0)) dut_nc (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flit(input logic [31:0] d);
      int n;
      a.rx_i   = 1'b1;
      a.data_i = d;
      #1;
      n = 0;
      while (!a.credit_o && n < 50) begin
         step();
         n++;
      end
      chk("flit_credit", a.credit_o, 1);
      step();
      a.rx_i = 1'b0;
      #1;
   endtask

   task automatic send_hdr(input logic [31:0] tgt, input logic [31:0] size,
                           input logic [31:0] svc);
      flit(tgt);
      flit(size);
      for (int k = 0; k < 13; k++) begin
         flit((k == 0) ? svc : 32'h100 + k);
      end
   endtask

   initial begin
      int got;
      logic pr;
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      a.rx_i        = 1'b0;
      a.data_i      = '0;
      a.hdr_ready_i = 1'b0;
      a.pld_ready_i = 1'b0;
      repeat (3) step();

      chk("rst_credit", a.credit_o, 0);
      chk("rst_hdr_valid", a.hdr_valid_o, 0);
      chk("rst_pld_valid", a.pld_valid_o, 0);
      chk("rst_err", a.err_o, 0);
      chk("rst_err_code", a.err_code_o, 0);
      chk("rst_target", a.target_o, 0);
      chk("rst_hdr_zero", |a.hdr_o, 0);
      chk("rst_psize", a.payload_size_o, 0);
      rst_n = 1'b1;
      #1;
      chk("idle_credit", a.credit_o, 1);

      // size 15, service 0x01, two payload flits
      send_hdr(32'hA5, 32'd15, 32'h01);
      chk("a_hdr_valid", a.hdr_valid_o, 1);
      chk("a_credit_hold", a.credit_o, 0);
      chk("a_target", a.target_o, 32'hA5);
      chk("a_service", a.service_o, 32'h01);
      chk("a_psize", a.payload_size_o, 2);
      chk("a_word5", a.hdr_o[5*32 +: 32], 32'h105);
      chk("a_word12", a.hdr_o[12*32 +: 32], 32'h10C);
      chk("a_no_pld", a.pld_valid_o, 0);
      a.hdr_ready_i = 1'b1;
      step();
      a.hdr_ready_i = 1'b0;
      a.pld_ready_i = 1'b1;
      a.rx_i        = 1'b1;
      a.data_i      = 32'hD0;
      #1;
      chk("a_pld0_valid", a.pld_valid_o, 1);
      chk("a_pld0_data", a.pld_data_o, 32'hD0);
      chk("a_pld0_last", a.pld_last_o, 0);
      chk("a_pld0_nohdr", a.hdr_valid_o, 0);
      chk("a_pld0_credit", a.credit_o, 1);
      step();
      a.data_i = 32'hD1;
      #1;
      chk("a_pld1_data", a.pld_data_o, 32'hD1);
      chk("a_pld1_last", a.pld_last_o, 1);
      step();
      a.rx_i = 1'b0;
      #1;
      chk("a_idle_credit", a.credit_o, 1);
      chk("a_idle_err", a.err_o, 0);

      // size 13, service 0x40: header only
      send_hdr(32'h7, 32'd13, 32'h40);
      chk("b_hdr_valid", a.hdr_valid_o, 1);
      chk("b_psize", a.payload_size_o, 0);
      chk("b_service", a.service_o, 32'h40);
      a.hdr_ready_i = 1'b1;
      step();
      a.hdr_ready_i = 1'b0;
      a.rx_i        = 1'b1;
      a.data_i      = 32'h55;
      #1;
      chk("b_idle_hdr", a.hdr_valid_o, 0);
      chk("b_idle_pld", a.pld_valid_o, 0);
      chk("b_idle_credit", a.credit_o, 1);

      // size 5: short packet dropped
      flit(32'h55);
      flit(32'd5);
      chk("c_err", a.err_o, 1);
      chk("c_err_code", a.err_code_o, 1);
      for (int i = 0; i < 5; i++) begin
         flit(32'hBB00 + i);
         chk("c_drop_hdr", a.hdr_valid_o, 0);
         chk("c_drop_pld", a.pld_valid_o, 0);
      end
      chk("c_err_done", a.err_o, 0);
      chk("c_err_code_held", a.err_code_o, 1);
      chk("c_target", a.target_o, 32'h55);

      // size 20, service 0x99: dropped by dut, presented by dut_nc
      send_hdr(32'h99A, 32'd20, 32'h99);
      chk("d_err", a.err_o, 1);
      chk("d_err_code", a.err_code_o, 2);
      chk("d_no_hdr", a.hdr_valid_o, 0);
      chk("d_target", a.target_o, 32'h99A);
      chk("d_nc_hdr_valid", b.hdr_valid_o, 1);
      chk("d_nc_service", b.service_o, 32'h99);
      chk("d_nc_psize", b.payload_size_o, 7);
      chk("d_nc_err", b.err_o, 0);
      a.hdr_ready_i = 1'b1;
      step();
      a.hdr_ready_i = 1'b0;
      a.pld_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         a.rx_i   = 1'b1;
         a.data_i = 32'hE0 + i;
         #1;
         chk("d_drop_pld", a.pld_valid_o, 0);
         chk("d_drop_credit", a.credit_o, 1);
         chk("d_nc_pld_valid", b.pld_valid_o, 1);
         chk("d_nc_pld_data", b.pld_data_o, 32'hE0 + i);
         chk("d_nc_pld_last", b.pld_last_o, (i == 6) ? 1 : 0);
         step();
      end
      a.rx_i = 1'b0;

      // size 17, service 0x10, sink ready toggling
      send_hdr(32'h3, 32'd17, 32'h10);
      chk("e_psize", a.payload_size_o, 4);
      a.hdr_ready_i = 1'b1;
      step();
      a.hdr_ready_i = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         pr            = (c % 2) == 0;
         a.pld_ready_i = pr;
         a.rx_i        = 1'b1;
         a.data_i      = 32'hC0 + got;
         #1;
         chk("e_credit", a.credit_o, pr);
         chk("e_valid", a.pld_valid_o, 1);
         if (pr) begin
            chk("e_data", a.pld_data_o, 32'hC0 + got);
            chk("e_last", a.pld_last_o, (got == 3) ? 1 : 0);
         end
         step();
         if (pr) got++;
      end
      a.rx_i = 1'b0;
      chk("e_beats", got, 4);
      #1;
      chk("e_idle_credit", a.credit_o, 1);

      // reset in the middle of a payload
      a.pld_ready_i = 1'b1;
      send_hdr(32'h1, 32'd14, 32'h31);
      a.hdr_ready_i = 1'b1;
      step();
      a.hdr_ready_i = 1'b0;
      a.rx_i        = 1'b1;
      a.data_i      = 32'hF0;
      #1;
      chk("f_pld_valid", a.pld_valid_o, 1);
      rst_n = 1'b0;
      #1;
      chk("f_rst_credit", a.credit_o, 0);
      chk("f_rst_pld", a.pld_valid_o, 0);
      chk("f_rst_hdr_zero", |a.hdr_o, 0);
      chk("f_rst_target", a.target_o, 0);
      chk("f_rst_err_code", a.err_code_o, 0);
      a.rx_i = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
      chk("f_idle_credit", a.credit_o, 1);
      chk("f_idle_hdr", a.hdr_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
